// File: rtl/vga_timing_gen.sv
// Raster timing generator (1280x800 @60 Hz CVT by default): position counters plus
// registered sync, blanking, line/frame strobes and a free-running frame counter.
module vga_timing_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 72,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 200,
   parameter int V_ACTIVE = 800,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 22,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   output logic [10:0] curr_x,
   output logic [9:0]  curr_y,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        line_start,
   output logic        frame_start,
   output logic [7:0]  frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

   generate
      if (H_TOTAL > 2048 || V_TOTAL > 1024 || H_TOTAL < 2 || V_TOTAL < 1) begin : g_size_check
         $error("vga_timing_gen: raster totals do not fit the 11-bit x / 10-bit y counters");
      end
   endgenerate

   logic [10:0] next_x_s;
   logic [9:0]  next_y_s;
   logic        hs_on_s;
   logic        vs_on_s;
   logic        von_s;
   logic        ls_s;
   logic        fs_s;

   // Next raster position and the status it implies; outputs are registered from these
   // so every flag lines up with the position it describes.
   always_comb begin
      next_x_s = curr_x;
      next_y_s = curr_y;
      if (curr_x == H_LAST) begin
         next_x_s = 11'd0;
         if (curr_y == V_LAST) begin
            next_y_s = 10'd0;
         end else begin
            next_y_s = curr_y + 10'd1;
         end
      end else begin
         next_x_s = curr_x + 11'd1;
         next_y_s = curr_y;
      end
      hs_on_s = (int'(next_x_s) >= H_ACTIVE + H_FP) &&
                (int'(next_x_s) <  H_ACTIVE + H_FP + H_SYNC);
      vs_on_s = (int'(next_y_s) >= V_ACTIVE + V_FP) &&
                (int'(next_y_s) <  V_ACTIVE + V_FP + V_SYNC);
      von_s   = (int'(next_x_s) < H_ACTIVE) && (int'(next_y_s) < V_ACTIVE);
      ls_s    = (next_x_s == 11'd0);
      fs_s    = (next_x_s == 11'd0) && (next_y_s == 10'd0);
   end

   // Output registers: reset wins over ce, and with ce low everything (strobes too) holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         curr_x      <= 11'd0;
         curr_y      <= 10'd0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         video_on    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= 8'd0;
      end else if (ce) begin
         curr_x      <= next_x_s;
         curr_y      <= next_y_s;
         hsync       <= hs_on_s ? HS_POL : ~HS_POL;
         vsync       <= vs_on_s ? VS_POL : ~VS_POL;
         video_on    <= von_s;
         line_start  <= ls_s;
         frame_start <= fs_s;
         if (fs_s) begin
            frame_count <= frame_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance and a tiny-raster instance share stimulus
// and are compared every cycle with a linear pixel-index model of the raster.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b0;

   logic [10:0] bx, sx;
   logic [9:0]  by, sy;
   logic        bhs, bvs, bvon, bls, bfs;
   logic        shs, svs, svon, sls, sfs;
   logic [7:0]  bfc, sfc;

   int checks = 0;
   int errors = 0;

   int idx    [2];
   int frames [2];
   bit in_rst [2];

   logic [33:0] obs [2];

   always #5 clk = ~clk;

   vga_timing_gen dut (
      .clk(clk), .rst(rst), .ce(ce),
      .curr_x(bx), .curr_y(by), .hsync(bhs), .vsync(bvs), .video_on(bvon),
      .line_start(bls), .frame_start(bfs), .frame_count(bfc)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
   ) dut_s (
      .clk(clk), .rst(rst), .ce(ce),
      .curr_x(sx), .curr_y(sy), .hsync(shs), .vsync(svs), .video_on(svon),
      .line_start(sls), .frame_start(sfs), .frame_count(sfc)
   );

   assign obs[0] = {bx, by, bhs, bvs, bvon, bls, bfs, bfc};
   assign obs[1] = {sx, sy, shs, svs, svon, sls, sfs, sfc};

   function automatic int h_total(int s);
      return (s == 0) ? 1680 : 16;
   endfunction

   function automatic int v_total(int s);
      return (s == 0) ? 831 : 9;
   endfunction

   // Expected outputs: position is the pixel index within the frame, everything else
   // follows from the raster rules applied to that position.
   function automatic logic [33:0] model_vec(int s);
      int ha, hf, hsw, va, vf, vsw, x, y;
      logic hs, vs, von, ls, fs;
      if (s == 0) begin
         ha = 1280; hf = 72; hsw = 128; va = 800; vf = 3; vsw = 6;
      end else begin
         ha = 8; hf = 2; hsw = 3; va = 4; vf = 1; vsw = 2;
      end
      if (in_rst[s]) return {11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      x   = idx[s] % h_total(s);
      y   = idx[s] / h_total(s);
      hs  = (x >= ha + hf && x < ha + hf + hsw) ? 1'b0 : 1'b1;
      vs  = (y >= va + vf && y < va + vf + vsw) ? 1'b1 : 1'b0;
      von = (x < ha && y < va);
      ls  = (x == 0);
      fs  = (idx[s] == 0);
      return {11'(x), 10'(y), hs, vs, von, ls, fs, 8'(frames[s] % 256)};
   endfunction

   task automatic advance(input logic r, input logic c);
      for (int s = 0; s < 2; s++) begin
         if (r) begin
            in_rst[s] = 1'b1;
            idx[s]    = 0;
            frames[s] = 0;
         end else if (c) begin
            in_rst[s] = 1'b0;
            idx[s]    = (idx[s] + 1) % (h_total(s) * v_total(s));
            if (idx[s] == 0) frames[s] = frames[s] + 1;
         end
      end
   endtask

   task automatic step(input logic r, input logic c);
      rst = r;
      ce  = c;
      @(posedge clk);
      advance(r, c);
      @(negedge clk);
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (obs[s] !== {11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_values dut%0d got %h exp %h", s, obs[s],
                     {11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
         end
      end
      step(1'b0, 1'b1);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (obs[s] !== {11'd1, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL first_edge dut%0d got %h exp %h", s, obs[s],
                     {11'd1, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
         end
      end
   endtask

   task automatic test_horizontal();
      int last_ls = -1;
      int hs_low = 0;
      int fall_x = -1;
      logic prev_von;
      for (int c = 0; c < 2 * 1680; c++) begin
         prev_von = bvon;
         step(1'b0, 1'b1);
         for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== model_vec(s)) begin
               errors++;
               $display("FAIL horiz_model dut%0d cyc %0d got %h exp %h", s, c, obs[s], model_vec(s));
            end
         end
         checks++;
         if (bvon !== (bx <= 11'd1279 && by <= 10'd799)) begin
            errors++;
            $display("FAIL video_on_range cyc %0d got %b at x %0d y %0d", c, bvon, bx, by);
         end
         if (prev_von && !bvon) fall_x = int'(bx);
         if (bhs == 1'b0) hs_low++;
         if (bls) begin
            if (last_ls >= 0) begin
               checks++;
               if (c - last_ls != 1680) begin
                  errors++;
                  $display("FAIL line_period got %0d exp 1680", c - last_ls);
               end
            end
            last_ls = c;
         end
      end
      checks++;
      if (fall_x != 1280) begin
         errors++;
         $display("FAIL video_on_fall_x got %0d exp 1280", fall_x);
      end
      checks++;
      if (hs_low != 256) begin
         errors++;
         $display("FAIL hsync_low_cycles got %0d exp 256", hs_low);
      end
   endtask

   task automatic test_ce_third();
      logic [33:0] prev;
      logic c_en;
      int last_rise = -1;
      int run = 0;
      int n_per = 0;
      for (int c = 0; c < 5040 * 2 + 30; c++) begin
         c_en = (c % 3 == 0);
         prev = obs[0];
         step(1'b0, c_en);
         for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== model_vec(s)) begin
               errors++;
               $display("FAIL ce_model dut%0d cyc %0d got %h exp %h", s, c, obs[s], model_vec(s));
            end
         end
         if (!c_en) begin
            checks++;
            if (obs[0] !== prev) begin
               errors++;
               $display("FAIL ce_hold cyc %0d got %h exp %h", c, obs[0], prev);
            end
         end
         if (bls && prev[9] == 1'b0) begin
            if (last_rise >= 0) begin
               n_per++;
               checks++;
               if (c - last_rise != 5040) begin
                  errors++;
                  $display("FAIL ce_line_period got %0d exp 5040", c - last_rise);
               end
            end
            last_rise = c;
         end
         if (bls) begin
            run++;
         end else if (run != 0) begin
            checks++;
            if (run != 3) begin
               errors++;
               $display("FAIL ce_strobe_hold got %0d exp 3", run);
            end
            run = 0;
         end
      end
      checks++;
      if (n_per < 1) begin
         errors++;
         $display("FAIL ce_line_seen got %0d exp >=1", n_per);
      end
   endtask

   task automatic test_mid_reset(input int sel);
      bit hit = 1'b0;
      int x, y;
      for (int k = 0; k < 2000 && !hit; k++) begin
         step(1'b0, 1'b1);
         x = idx[sel] % h_total(sel);
         y = idx[sel] / h_total(sel);
         if (sel == 0) hit = (x == 1400);
         else          hit = (x >= 10 && x < 13 && y >= 5 && y < 7);
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL mid_reset_reach dut%0d got no target exp target", sel);
      end
      checks++;
      if (obs[sel] !== model_vec(sel)) begin
         errors++;
         $display("FAIL mid_reset_pre dut%0d got %h exp %h", sel, obs[sel], model_vec(sel));
      end
      step(1'b1, 1'b0);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (obs[s] !== {11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL mid_reset dut%0d got %h exp %h", s, obs[s],
                     {11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
         end
      end
      step(1'b0, 1'b0);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (obs[s] !== model_vec(s)) begin
            errors++;
            $display("FAIL post_reset_hold dut%0d got %h exp %h", s, obs[s], model_vec(s));
         end
      end
   endtask

   task automatic test_frames();
      int n_fs = 0;
      int last_fs = -1;
      logic prev_fs;
      for (int c = 0; c < 256 * 144 + 3; c++) begin
         prev_fs = sfs;
         step(1'b0, ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b1);
         for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== model_vec(s)) begin
               errors++;
               $display("FAIL frame_model dut%0d cyc %0d got %h exp %h", s, c, obs[s], model_vec(s));
            end
         end
         if (sfs && !prev_fs) begin
            n_fs++;
            checks++;
            if (sfc !== 8'(n_fs % 256) || sls !== 1'b1) begin
               errors++;
               $display("FAIL frame_wrap got fc %0d ls %b exp fc %0d ls 1", sfc, sls, n_fs % 256);
            end
            if (last_fs >= 0) begin
               checks++;
               if (c - last_fs != 144) begin
                  errors++;
                  $display("FAIL frame_period got %0d exp 144", c - last_fs);
               end
            end
            last_fs = c;
         end
      end
      checks++;
      if (n_fs != 256 || sfc !== 8'd0) begin
         errors++;
         $display("FAIL frame_count_wrap got frames %0d fc %0d exp frames 256 fc 0", n_fs, sfc);
      end
   endtask

   task automatic test_random_ce();
      logic c_en;
      for (int c = 0; c < 3000; c++) begin
         c_en = ($urandom_range(0, 3) != 0);
         step(1'b0, c_en);
         for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== model_vec(s)) begin
               errors++;
               $display("FAIL random_ce dut%0d cyc %0d got %h exp %h", s, c, obs[s], model_vec(s));
            end
         end
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         idx[s]    = 0;
         frames[s] = 0;
         in_rst[s] = 1'b1;
      end
      @(negedge clk);
      test_reset();
      test_horizontal();
      test_ce_third();
      test_mid_reset(0);
      test_mid_reset(1);
      test_frames();
      test_random_ce();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the 1280x800 @60 Hz display (CVT timing, 83.5 MHz pixel rate).
- Produces the `curr_x`/`curr_y` raster position consumed by the background-address stage and the sprite/address stages alongside it.
- Also produces registered hsync/vsync, a `video_on` blanking flag, line/frame strobes and a frame counter for game animation.
- Sits directly upstream of the figure-address stages and drives the VGA connector pins.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 72, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BP, 200, horizontal back porch (pixels)
- V_ACTIVE, 800, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 22, vertical back porch (lines)
- HS_POL, 0, active level of hsync (0 = active-low)
- VS_POL, 1, active level of vsync (1 = active-high)

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous reset, active-high
- ce  in  1  pixel clock enable; timing advances only on edges with ce=1
- curr_x  out  11  horizontal position, 0..H_TOTAL-1 (H_TOTAL = 1680)
- curr_y  out  10  vertical position, 0..V_TOTAL-1 (V_TOTAL = 831)
- hsync  out  1  horizontal sync to connector
- vsync  out  1  vertical sync to connector
- video_on  out  1  1 when curr_x < H_ACTIVE and curr_y < V_ACTIVE
- line_start  out  1  one-ce pulse when curr_x becomes 0
- frame_start  out  1  one-ce pulse when (curr_x, curr_y) becomes (0, 0)
- frame_count  out  8  frames completed, wraps at 255 -> 0

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high: sampled only on posedge clk, and overrides ce.
- Reset values:
  - curr_x = 0, curr_y = 0, frame_count = 0
  - video_on = 0, line_start = 0, frame_start = 0
  - hsync = ~HS_POL, vsync = ~VS_POL (both inactive)
- Counters, on each clk edge with rst=0 and ce=1:
  - If curr_x == H_TOTAL-1: curr_x <= 0; curr_y <= (curr_y == V_TOTAL-1) ? 0 : curr_y+1.
  - Otherwise curr_x <= curr_x+1 and curr_y holds.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Widths: 11 bits for x, 10 bits for y. Constants must fit these widths; elaborate-time check fails otherwise.
- With ce=0 and rst=0, every output holds, including strobes. A strobe therefore stays high for all cycles until the next ce=1 edge, and consumers qualify it with ce.
- All outputs are registered. Status outputs are decoded from the next-state counter values, so they are coincident with the curr_x/curr_y they describe, with no lag.
- Sync decoding on the next-state counters:
  - hsync = HS_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (x = 1352..1479); else ~HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (y = 803..808); else ~VS_POL.
- line_start = 1 when next x == 0. frame_start = 1 when next x == 0 and next y == 0.
- frame_count increments (mod 256) on the same edge that sets frame_start. frame_count is therefore 1 while frame_start is high at the start of the 2nd frame.
- Reset release: the first ce=1 edge moves to (1, 0) with video_on=1. Pixel (0, 0) of the first frame after reset is blanked, and no frame_start is issued for that frame.
- Reset mid-frame: the next edge forces all reset values regardless of ce. Sync outputs go inactive immediately, even if asserted mid-pulse.
- A wrap at (H_TOTAL-1, V_TOTAL-1) produces line_start and frame_start on the same edge.

Test Plan:
- Reset then ce=1 constant:
  - first edge after release gives curr_x=1, curr_y=0, video_on=1, hsync=1, vsync=0;
  - curr_x reaches 1679 then 0 with curr_y=1 and line_start=1 for exactly one cycle.
- Horizontal sync/blank, ce=1:
  - video_on falls on the edge where curr_x becomes 1280;
  - hsync=0 exactly for curr_x 1352..1479 (128 cycles);
  - line period is 1680 cycles.
- Full frame:
  - vsync=1 exactly for curr_y 803..808 (6x1680 cycles);
  - frame period is 1,396,080 cycles;
  - at wrap, frame_start=1, line_start=1 and frame_count goes 0->1; after 256 frames frame_count returns to 0.
- ce=1 one cycle in three (83.5 MHz from a 250.5 MHz clk):
  - outputs change only after ce edges;
  - line_start held across the two ce=0 cycles;
  - line period is 5040 clk.
- Assert rst for 1 cycle while curr_x=1400, curr_y=805 (both syncs active), with ce=0 during reset:
  - next edge gives curr_x=0, curr_y=0, hsync=1, vsync=0, video_on=0, frame_count=0.
- Cross-check against the background-address stage: with ce=1, every cycle with video_on=1 has curr_x<=1279 and curr_y<=799; no cycle with video_on=0 has both in range.
